// File: rtl/noc_out_sched_if.sv
// Flit-request / grant bundle between the input-port FIFOs and one output scheduler.
// The master side owns the FIFO heads; the slave side is the scheduler.
interface noc_out_sched_if #(
  parameter int NUM_INPUTS = 5
);
  logic [NUM_INPUTS-1:0] req;
  logic [NUM_INPUTS-1:0] req_tail;
  logic [NUM_INPUTS-1:0] grant;
  logic                  grant_valid;

  modport master (
    output req,
    output req_tail,
    input  grant,
    input  grant_valid
  );

  modport slave (
    input  req,
    input  req_tail,
    output grant,
    output grant_valid
  );
endinterface

// File: rtl/noc_out_sched.sv
// Per-output-port scheduler: packet-atomic round-robin arbitration over the input FIFOs,
// gated by a downstream credit counter and the link-up status.
module noc_out_sched #(
  parameter  int NUM_INPUTS = 5,
  parameter  int CREDIT_MAX = 8,
  localparam int CW         = $clog2(CREDIT_MAX + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                link_up_i,
  input  logic                credit_in_i,
  noc_out_sched_if.slave      port_if,
  output logic [CW-1:0]       credits_o,
  output logic                locked_o,
  output logic                pkt_abort_o,
  output logic                credit_err_o
);

  localparam int            PW   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [CW-1:0] CMAX = CW'(CREDIT_MAX);

  typedef enum logic [1:0] {
    LINK_DOWN = 2'd0,
    IDLE      = 2'd1,
    LOCKED    = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]         lock_idx_q, lock_idx_d;
  logic [CW-1:0]         credits_q, credits_d;
  logic                  pkt_abort_q, pkt_abort_d;
  logic                  credit_err_q;
  logic                  cerr_set_s;
  logic [CW:0]           cred_sum_s;
  logic [PW-1:0]         cand_s;
  logic                  hit_s;
  logic                  win_found_s;
  logic [PW-1:0]         win_idx_s;
  logic [NUM_INPUTS-1:0] grant_s;
  logic                  grant_valid_s;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    sum = (sum >= NUM_INPUTS) ? (sum - NUM_INPUTS) : sum;
    return sum[PW-1:0];
  endfunction

  function automatic logic [NUM_INPUTS-1:0] onehot(input logic [PW-1:0] idx);
    logic [NUM_INPUTS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin search: first requester at or after rr_ptr, wrapping.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    hit_s       = 1'b0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      cand_s      = wrap_add(rr_ptr_q, k);
      hit_s       = port_if.req[cand_s] & ~win_found_s;
      win_idx_s   = hit_s ? cand_s : win_idx_s;
      win_found_s = win_found_s | hit_s;
    end
  end

  // Next-state, pointer update and grant generation.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_idx_d  = lock_idx_q;
    grant_s     = '0;
    pkt_abort_d = 1'b0;
    case (state_q)
      LINK_DOWN: begin
        if (link_up_i) begin
          state_d = IDLE;
        end else begin
          state_d = LINK_DOWN;
        end
      end
      IDLE: begin
        if (!link_up_i) begin
          state_d = LINK_DOWN;
        end else if (win_found_s && (credits_q != '0)) begin
          grant_s = onehot(win_idx_s);
          if (port_if.req_tail[win_idx_s]) begin
            rr_ptr_d = wrap_add(win_idx_s, 1);
          end else begin
            state_d    = LOCKED;
            lock_idx_d = win_idx_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOCKED: begin
        if (!link_up_i) begin
          state_d     = LINK_DOWN;
          pkt_abort_d = 1'b1;
        end else if (port_if.req[lock_idx_q] && (credits_q != '0)) begin
          grant_s = onehot(lock_idx_q);
          if (port_if.req_tail[lock_idx_q]) begin
            state_d  = IDLE;
            rr_ptr_d = wrap_add(lock_idx_q, 1);
          end else begin
            state_d = LOCKED;
          end
        end else begin
          state_d = LOCKED;
        end
      end
      default: begin
        state_d = LINK_DOWN;
      end
    endcase
  end

  assign grant_valid_s = |grant_s;

  // Credit counter: saturate at CREDIT_MAX and flag the excess return.
  always_comb begin
    credits_d  = credits_q;
    cerr_set_s = 1'b0;
    cred_sum_s = '0;
    case (state_q)
      LINK_DOWN: begin
        credits_d = link_up_i ? CMAX : '0;
      end
      IDLE, LOCKED: begin
        if (!link_up_i) begin
          credits_d = '0;
        end else begin
          cred_sum_s = {1'b0, credits_q} + {{CW{1'b0}}, credit_in_i}
                     - {{CW{1'b0}}, grant_valid_s};
          if (cred_sum_s > {1'b0, CMAX}) begin
            credits_d  = CMAX;
            cerr_set_s = 1'b1;
          end else begin
            credits_d = cred_sum_s[CW-1:0];
          end
        end
      end
      default: begin
        credits_d = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LINK_DOWN;
      rr_ptr_q     <= '0;
      lock_idx_q   <= '0;
      credits_q    <= '0;
      pkt_abort_q  <= 1'b0;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      lock_idx_q   <= lock_idx_d;
      credits_q    <= credits_d;
      pkt_abort_q  <= pkt_abort_d;
      credit_err_q <= credit_err_q | cerr_set_s;
    end
  end

  assign port_if.grant       = grant_s;
  assign port_if.grant_valid = grant_valid_s;
  assign credits_o           = credits_q;
  assign locked_o            = (state_q == LOCKED);
  assign pkt_abort_o         = pkt_abort_q;
  assign credit_err_o        = credit_err_q;

endmodule

// File: tb/tb_noc_out_sched.sv
// Directed bench for noc_out_sched: a vector table for link-up, round-robin and packet lock,
// then hand-written sequences for credit exhaustion, link drop, overflow and reset mid-packet.
module tb_noc_out_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       link_up;
  logic       credit_in;
  logic [3:0] credits;
  logic       locked;
  logic       pkt_abort;
  logic       credit_err;

  int n_tests = 0;
  int n_fail  = 0;

  noc_out_sched_if #(.NUM_INPUTS(5)) sif ();

  noc_out_sched #(.NUM_INPUTS(5), .CREDIT_MAX(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .link_up_i    (link_up),
    .credit_in_i  (credit_in),
    .port_if      (sif),
    .credits_o    (credits),
    .locked_o     (locked),
    .pkt_abort_o  (pkt_abort),
    .credit_err_o (credit_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] req;
    logic [4:0] tail;
    logic       link;
    logic       cin;
    logic [4:0] exp_grant;
    logic [3:0] exp_credits;
    logic       exp_locked;
    logic       exp_abort;
    logic       exp_cerr;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive at the falling edge, settle, then the caller samples.
  task automatic cyc(input logic [4:0] r, input logic [4:0] t, input logic l, input logic c);
    @(negedge clk);
    sif.req      = r;
    sif.req_tail = t;
    link_up      = l;
    credit_in    = c;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    link_up      = 1'b0;
    credit_in    = 1'b0;
    sif.req      = 5'b00000;
    sif.req_tail = 5'b00000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic bring_up();
    cyc(5'b00000, 5'b00000, 1'b1, 1'b0);
    cyc(5'b00000, 5'b00000, 1'b1, 1'b0);
    chk("bringup_credits", 32'(credits), 32'd8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gcount;

    //            req       tail      lk    cin   grant     cr    lk    ab    ce
    vecs[0]  = '{5'b00000, 5'b00000, 1'b1, 1'b0, 5'b00000, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{5'b00000, 5'b00000, 1'b1, 1'b0, 5'b00000, 4'd8, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{5'b00000, 5'b00000, 1'b1, 1'b0, 5'b00000, 4'd8, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{5'b00000, 5'b00000, 1'b1, 1'b0, 5'b00000, 4'd8, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{5'b10101, 5'b11111, 1'b1, 1'b1, 5'b00001, 4'd8, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{5'b10101, 5'b11111, 1'b1, 1'b1, 5'b00100, 4'd8, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{5'b10101, 5'b11111, 1'b1, 1'b1, 5'b10000, 4'd8, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{5'b10101, 5'b11111, 1'b1, 1'b1, 5'b00001, 4'd8, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{5'b00000, 5'b00000, 1'b1, 1'b0, 5'b00000, 4'd8, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{5'b01010, 5'b01000, 1'b1, 1'b0, 5'b00010, 4'd8, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{5'b01000, 5'b01000, 1'b1, 1'b0, 5'b00000, 4'd7, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{5'b01010, 5'b01000, 1'b1, 1'b0, 5'b00010, 4'd7, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{5'b01010, 5'b01010, 1'b1, 1'b0, 5'b00010, 4'd6, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{5'b01000, 5'b01000, 1'b1, 1'b0, 5'b01000, 4'd5, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{5'b00000, 5'b00000, 1'b1, 1'b0, 5'b00000, 4'd4, 1'b0, 1'b0, 1'b0};

    do_reset();
    chk("reset_grant", 32'(sif.grant), 32'd0);
    chk("reset_gvalid", 32'(sif.grant_valid), 32'd0);
    chk("reset_credits", 32'(credits), 32'd0);
    chk("reset_locked", 32'(locked), 32'd0);
    chk("reset_abort", 32'(pkt_abort), 32'd0);
    chk("reset_cerr", 32'(credit_err), 32'd0);

    for (int i = 0; i < 15; i++) begin
      cyc(vecs[i].req, vecs[i].tail, vecs[i].link, vecs[i].cin);
      chk($sformatf("vec%0d_grant", i), 32'(sif.grant), 32'(vecs[i].exp_grant));
      chk($sformatf("vec%0d_gvalid", i), 32'(sif.grant_valid), 32'(|vecs[i].exp_grant));
      chk($sformatf("vec%0d_credits", i), 32'(credits), 32'(vecs[i].exp_credits));
      chk($sformatf("vec%0d_locked", i), 32'(locked), 32'(vecs[i].exp_locked));
      chk($sformatf("vec%0d_abort", i), 32'(pkt_abort), 32'(vecs[i].exp_abort));
      chk($sformatf("vec%0d_cerr", i), 32'(credit_err), 32'(vecs[i].exp_cerr));
    end

    // Credit exhaustion, then a single returned credit with no bypass.
    do_reset();
    bring_up();
    gcount = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(5'b00001, 5'b00001, 1'b1, 1'b0);
      gcount = gcount + (sif.grant_valid ? 1 : 0);
    end
    chk("exhaust_count", 32'(gcount), 32'd8);
    chk("exhaust_grant", 32'(sif.grant), 32'd0);
    chk("exhaust_credits", 32'(credits), 32'd0);
    cyc(5'b00001, 5'b00001, 1'b1, 1'b1);
    chk("no_bypass_grant", 32'(sif.grant), 32'd0);
    cyc(5'b00001, 5'b00001, 1'b1, 1'b0);
    chk("refill_grant", 32'(sif.grant), 32'd1);
    chk("refill_credits", 32'(credits), 32'd1);
    cyc(5'b00001, 5'b00001, 1'b1, 1'b0);
    chk("refill_drained", 32'(sif.grant), 32'd0);

    // Link drop after the head of a 4-flit packet from input 2.
    do_reset();
    bring_up();
    cyc(5'b00100, 5'b00000, 1'b1, 1'b0);
    chk("drop_head_grant", 32'(sif.grant), 32'b00100);
    cyc(5'b00100, 5'b00000, 1'b0, 1'b0);
    chk("drop_same_cycle_grant", 32'(sif.grant), 32'd0);
    chk("drop_still_locked", 32'(locked), 32'd1);
    cyc(5'b00100, 5'b00000, 1'b0, 1'b0);
    chk("drop_abort", 32'(pkt_abort), 32'd1);
    chk("drop_credits", 32'(credits), 32'd0);
    chk("drop_locked", 32'(locked), 32'd0);
    cyc(5'b00100, 5'b00000, 1'b0, 1'b0);
    chk("drop_abort_pulse", 32'(pkt_abort), 32'd0);
    cyc(5'b00000, 5'b00000, 1'b1, 1'b0);
    cyc(5'b00000, 5'b00000, 1'b1, 1'b0);
    chk("drop_reload", 32'(credits), 32'd8);

    // Credit overflow at full credits; the error bit is sticky.
    cyc(5'b00000, 5'b00000, 1'b1, 1'b1);
    chk("ovf_pre_cerr", 32'(credit_err), 32'd0);
    cyc(5'b00000, 5'b00000, 1'b1, 1'b0);
    chk("ovf_credits", 32'(credits), 32'd8);
    chk("ovf_cerr", 32'(credit_err), 32'd1);
    cyc(5'b00000, 5'b00000, 1'b0, 1'b0);
    cyc(5'b00000, 5'b00000, 1'b1, 1'b0);
    chk("ovf_cerr_sticky", 32'(credit_err), 32'd1);

    // Reset mid-packet: back to reset values without an abort pulse.
    cyc(5'b00000, 5'b00000, 1'b1, 1'b0);
    cyc(5'b01000, 5'b00000, 1'b1, 1'b0);
    cyc(5'b01000, 5'b00000, 1'b1, 1'b0);
    chk("rstpkt_locked_before", 32'(locked), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    @(negedge clk);
    rst     = 1'b0;
    link_up = 1'b0;
    #1;
    chk("rstpkt_locked", 32'(locked), 32'd0);
    chk("rstpkt_abort", 32'(pkt_abort), 32'd0);
    chk("rstpkt_credits", 32'(credits), 32'd0);
    chk("rstpkt_cerr", 32'(credit_err), 32'd0);
    cyc(5'b01000, 5'b00000, 1'b0, 1'b0);
    chk("rstpkt_abort_after", 32'(pkt_abort), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_out_sched.md
# noc_out_sched

Per-output-port scheduler for the NoC router. Sits between the input-port FIFOs and one output queue, and picks which input may dequeue a flit each cycle. Arbitration is round-robin and packet-atomic: once a head flit is granted, the port is held until that packet's tail flit passes. Grants are gated by a downstream credit counter and by the port's link-up status.

## Interface
Parameters:
- NUM_INPUTS, 5, number of requesting input ports
- CREDIT_MAX, 8, downstream buffer depth; credit counter reload value
- CW, $clog2(CREDIT_MAX+1), credit counter width (derived, not overridden)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- link_up  in  1  output link operational
- req  in  NUM_INPUTS  bit i: input i FIFO non-empty and its head flit routes to this output
- req_tail  in  NUM_INPUTS  bit i: input i head flit is a tail flit (single-flit packets have tail=1)
- credit_in  in  1  one-cycle pulse = one downstream buffer slot freed
- grant  out  NUM_INPUTS  one-hot or zero; used directly as FIFO rd_en for this output
- grant_valid  out  1  OR of grant
- credits  out  CW  current credit count
- locked  out  1  packet in progress (state LOCKED)
- pkt_abort  out  1  one-cycle pulse: link dropped mid-packet
- credit_err  out  1  sticky; credit return beyond CREDIT_MAX

## Operation
- States:
  - LINK_DOWN (reset state): no grants.
  - IDLE: arbitrate among all requesters.
  - LOCKED: grant only lock_idx.
- LINK_DOWN -> IDLE when link_up=1. credits loads CREDIT_MAX on that edge.
- IDLE:
  - Eligible when credits!=0 and link_up=1.
  - Winner is the first set req bit at or after rr_ptr, wrapping modulo NUM_INPUTS.
  - If the winner's req_tail=1: stay in IDLE and set rr_ptr = winner+1 (mod NUM_INPUTS).
  - Otherwise: go to LOCKED and set lock_idx = winner.
- LOCKED:
  - Grant lock_idx when req[lock_idx]=1, credits!=0 and link_up=1.
  - Other requesters are ignored.
  - A bubble (req[lock_idx]=0) produces no grant and keeps the lock.
  - A granted flit with req_tail=1 returns the block to IDLE and sets rr_ptr = lock_idx+1.
- link_up=0 in IDLE or LOCKED: next state is LINK_DOWN, credits clears to 0, and grant is 0 combinationally in the same cycle.
  - If the state was LOCKED, pkt_abort pulses on the next cycle.
  - rr_ptr is preserved across the link drop.
- Credit arithmetic:
  - credits_next = credits - grant_valid + credit_in.
  - A simultaneous grant and credit_in leaves credits unchanged.
  - If the result would exceed CREDIT_MAX, credits holds CREDIT_MAX and credit_err sets; credit_err clears only on rst.
  - credit_in is ignored in LINK_DOWN.
  - credits never underflows because a grant requires credits!=0.
- There is no credit bypass: a credit_in arriving in a cycle where credits==0 enables a grant only from the next cycle.

## Timing
- grant and grant_valid are combinational from registered state plus req, req_tail and link_up. The FIFO pops on the same edge that the grant is sampled.
- Registered on the rising edge of the grant cycle: credits, state, rr_ptr, lock_idx.
- locked reflects the state after the edge. The first flit of a multi-flit packet is granted while locked=0.
- pkt_abort is registered and high for exactly one cycle.
- Maximum throughput is one grant per cycle per output.
- Reset values: grant=0, grant_valid=0, credits=0, locked=0, pkt_abort=0, credit_err=0, state=LINK_DOWN, rr_ptr=0, lock_idx=0.
- Asserting rst mid-packet returns to these values at the next edge without a pkt_abort pulse.

## Test plan
- Reset, then link_up=1, no req:
  - Next cycle credits=8, grant=0.
  - Two CREDIT_MAX-free cycles later, still credits=8 and credit_err=0.
- Round-robin fairness: req=5'b10101, all req_tail=1, credit_in=1 every cycle.
  - Grants cycle 00001, 00100, 10000, 00001.
  - credits stays 8.
- Packet lock:
  - Input 1 sends a 3-flit packet (tails at flit 3) with a one-cycle bubble after flit 1. Input 3 requests throughout.
  - Input 1 receives 3 grants.
  - No grant during the bubble; locked=1 throughout the packet.
  - Input 3 is granted only on the cycle after input 1's tail.
- Credit exhaustion: no credit_in, req=00001 single-flit packets continuously.
  - Exactly 8 grants, then grant=0 with credits=0.
  - A credit_in pulse produces one grant on the following cycle.
- Link drop mid-packet: after the head of a 4-flit packet from input 2 is granted, drop link_up.
  - grant=0 in the same cycle.
  - Next cycle: pkt_abort=1 for one cycle, credits=0, locked=0.
  - Re-raising link_up reloads credits=8.
- Credit overflow: at credits=8 with no grant, pulse credit_in.
  - credits stays 8.
  - credit_err=1 and stays set until rst.
